// File: rtl/player_motion_ctl.sv
// Per-frame motion controller for one player sprite: walking with clamping, jump with gravity, landing lockout.
// Latency: position/state update on the clock edge where vblnk rises; new values visible one cycle later.
// No backpressure: button inputs are level-sampled once per frame tick; outputs hold between ticks.
module player_motion_ctl #(
  parameter int X_INIT   = 30,
  parameter int Y_GROUND = 550,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 894,
  parameter int Y_MIN    = 0,
  parameter int SPEED    = 4,
  parameter int JUMP_V0  = 16,
  parameter int GRAVITY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        enable,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        jump,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        facing_left,
  output logic [1:0]  state,
  output logic        airborne
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_AIR  = 2'd2,
    ST_LAND = 2'd3
  } st_t;

  // 12-bit views of the bounds so clamping arithmetic can never wrap
  localparam logic [11:0]        X_MIN_W = 12'(X_MIN);
  localparam logic [11:0]        X_MAX_W = 12'(X_MAX);
  localparam logic [11:0]        SPEED_W = 12'(SPEED);
  localparam logic signed [11:0] Y_GND_S = 12'(Y_GROUND);
  localparam logic signed [11:0] Y_MIN_S = 12'(Y_MIN);
  localparam logic signed [5:0]  V0_S    = 6'(JUMP_V0);
  localparam logic signed [5:0]  GRAV_S  = 6'(GRAVITY);

  st_t               cur_st, nxt_st;
  logic              vblnk_q;
  logic              tick;
  logic              go_left, go_right, h_any;
  logic [10:0]       x_nxt, y_nxt;
  logic signed [5:0] vy, vy_nxt;
  logic              face_nxt;
  logic signed [11:0] ny;

  // One tick per vblnk rising edge; vblnk_q resets high so reset release never fakes an edge
  assign tick = vblnk & ~vblnk_q;

  // Conflicting or absent buttons mean no horizontal request; a disabled player never walks
  assign go_left  = enable & move_left & ~move_right;
  assign go_right = enable & move_right & ~move_left;
  assign h_any    = go_left | go_right;

  // Candidate next y while airborne (positive vy moves the sprite up the screen)
  assign ny = $signed({1'b0, ypos}) - $signed({{6{vy[5]}}, vy});

  assign state    = cur_st;
  assign airborne = (cur_st == ST_AIR);

  // Edge detector register for the frame tick
  always_ff @(posedge clk) begin
    if (!rst) vblnk_q <= 1'b1;
    else      vblnk_q <= vblnk;
  end

  // Next-state and next-datapath values; everything holds unless this is a tick cycle
  always_comb begin
    nxt_st   = cur_st;
    x_nxt    = xpos;
    y_nxt    = ypos;
    vy_nxt   = vy;
    face_nxt = facing_left;

    if (tick) begin
      // Horizontal walk works in every vertical state, including mid-air and landing
      if (go_left) begin
        x_nxt    = ({1'b0, xpos} < X_MIN_W + SPEED_W) ? 11'(X_MIN) : xpos - 11'(SPEED);
        face_nxt = 1'b1;
      end else if (go_right) begin
        x_nxt    = ({1'b0, xpos} + SPEED_W > X_MAX_W) ? 11'(X_MAX) : xpos + 11'(SPEED);
        face_nxt = 1'b0;
      end

      case (cur_st)
        ST_IDLE, ST_WALK: begin
          if (enable && jump) begin
            nxt_st = ST_AIR;
            vy_nxt = V0_S;
          end else begin
            nxt_st = h_any ? ST_WALK : ST_IDLE;
          end
        end
        ST_AIR: begin
          // Gravity keeps acting even if control is withdrawn mid-jump
          if (ny >= Y_GND_S) begin
            y_nxt  = 11'(Y_GROUND);
            vy_nxt = '0;
            nxt_st = ST_LAND;
          end else if (ny < Y_MIN_S) begin
            y_nxt  = 11'(Y_MIN);
            vy_nxt = '0;
          end else begin
            y_nxt  = ny[10:0];
            vy_nxt = vy - GRAV_S;
          end
        end
        ST_LAND: begin
          // Jump deliberately ignored here: one frame lockout after touchdown
          nxt_st = h_any ? ST_WALK : ST_IDLE;
        end
        default: nxt_st = ST_IDLE;
      endcase
    end
  end

  // Vertical FSM state register
  always_ff @(posedge clk) begin
    if (!rst) cur_st <= ST_IDLE;
    else      cur_st <= nxt_st;
  end

  // Position, velocity and facing registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      xpos        <= 11'(X_INIT);
      ypos        <= 11'(Y_GROUND);
      vy          <= '0;
      facing_left <= 1'b0;
    end else begin
      xpos        <= x_nxt;
      ypos        <= y_nxt;
      vy          <= vy_nxt;
      facing_left <= face_nxt;
    end
  end

endmodule

// File: tb/tb_player_motion_ctl.sv
// Bench for player_motion_ctl: directed frame sequences plus randomized frames.
// Expected values come from a frame-level integer model of the motion rules.
// Outputs are sampled on the falling clock edge, away from the update edge.
module tb_player_motion_ctl;

  logic        clk = 1'b0;
  logic        rst, vblnk, enable, move_left, move_right, jump;
  logic [10:0] xpos, ypos;
  logic        facing_left, airborne;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;

  // Reference model state: plain integers, one update per frame
  int mx, my, mvy, mst;
  bit mface;

  player_motion_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .vblnk       (vblnk),
    .enable      (enable),
    .move_left   (move_left),
    .move_right  (move_right),
    .jump        (jump),
    .xpos        (xpos),
    .ypos        (ypos),
    .facing_left (facing_left),
    .state       (state),
    .airborne    (airborne)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".xpos"},     32'(xpos),        32'(mx));
    check({tag, ".ypos"},     32'(ypos),        32'(my));
    check({tag, ".state"},    32'(state),       32'(mst));
    check({tag, ".facing"},   32'(facing_left), 32'(mface));
    check({tag, ".airborne"}, 32'(airborne),    32'(mst == 2));
  endtask

  task automatic model_reset();
    mx = 30; my = 550; mvy = 0; mst = 0; mface = 0;
  endtask

  // One frame of the motion rules (0 IDLE, 1 WALK, 2 AIR, 3 LAND)
  task automatic model_tick(bit en, bit l, bit r, bit j);
    int dir;
    int ny;
    dir = 0;
    if (en && l && !r) dir = -1;
    if (en && r && !l) dir = 1;
    if (dir < 0) begin
      mx = (mx - 4 < 0) ? 0 : mx - 4;
      mface = 1;
    end else if (dir > 0) begin
      mx = (mx + 4 > 894) ? 894 : mx + 4;
      mface = 0;
    end
    case (mst)
      0, 1: begin
        if (en && j) begin mst = 2; mvy = 16; end
        else mst = (dir != 0) ? 1 : 0;
      end
      2: begin
        ny = my - mvy;
        if (ny >= 550)  begin my = 550; mvy = 0; mst = 3; end
        else if (ny < 0) begin my = 0; mvy = 0; end
        else begin my = ny; mvy = mvy - 1; end
      end
      default: mst = (dir != 0) ? 1 : 0;
    endcase
  endtask

  // One frame: vblnk high for hi cycles, low for lo cycles; inputs scrambled after the tick
  task automatic frame(bit en, bit l, bit r, bit j, int hi, int lo);
    @(negedge clk);
    enable = en; move_left = l; move_right = r; jump = j; vblnk = 1'b1;
    model_tick(en, l, r, j);
    @(negedge clk);
    check_all("tick");
    enable = 1'($urandom); move_left = 1'($urandom);
    move_right = 1'($urandom); jump = 1'($urandom);
    repeat (hi - 1) @(negedge clk);
    check_all("hold_hi");
    vblnk = 1'b0;
    repeat (lo) @(negedge clk);
    check_all("hold_lo");
  endtask

  task automatic do_reset(bit vb);
    @(negedge clk);
    rst = 1'b0; vblnk = vb; enable = 1'b1; move_left = 1'b0; move_right = 1'b1; jump = 1'b1;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst = 1'b1;
  endtask

  initial begin
    int xs, ymin;
    rst = 1'b0; vblnk = 1'b0; enable = 1'b0;
    move_left = 1'b0; move_right = 1'b0; jump = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset, then a long vblnk pulse gives exactly one step
    do_reset(1'b0);
    frame(1, 0, 1, 0, 10, 3);
    check("long_vblnk.x", 32'(xpos), 32'd34);
    check("long_vblnk.st", 32'(state), 32'd1);
    check("long_vblnk.y", 32'(ypos), 32'd550);

    // Reset released with vblnk already high: no tick until the next rising edge
    do_reset(1'b1);
    @(negedge clk); enable = 1'b1; move_right = 1'b1; jump = 1'b0;
    repeat (3) @(negedge clk);
    check("rel_hi.x", 32'(xpos), 32'd30);
    check_all("rel_hi");
    vblnk = 1'b0;
    repeat (2) @(negedge clk);
    frame(1, 0, 1, 0, 2, 2);
    check("rel_hi_tick.x", 32'(xpos), 32'd34);

    // Left clamp, then march right to 892 and clamp at 894
    repeat (12) frame(1, 1, 0, 0, 1, 1);
    check("left_sat.x", 32'(xpos), 32'd0);
    repeat (223) frame(1, 0, 1, 0, 1, 1);
    check("walk.x892", 32'(xpos), 32'd892);
    frame(1, 0, 1, 0, 1, 1);
    check("clamp_r1.x", 32'(xpos), 32'd894);
    frame(1, 0, 1, 0, 1, 1);
    check("clamp_r2.x", 32'(xpos), 32'd894);
    repeat (223) frame(1, 1, 0, 0, 1, 1);
    check("walk.x2", 32'(xpos), 32'd2);
    frame(1, 1, 0, 0, 1, 1);
    check("clamp_l.x", 32'(xpos), 32'd0);
    check("clamp_l.face", 32'(facing_left), 32'd1);

    // Both directions at once: no motion, IDLE
    repeat (20) frame(1, 0, 1, 0, 1, 1);
    xs = 32'(xpos);
    repeat (5) frame(1, 1, 1, 0, 2, 1);
    check("both.x", 32'(xpos), 32'(xs));
    check("both.st", 32'(state), 32'd0);

    // Single jump pulse: full trajectory with landing and IDLE afterwards
    frame(1, 0, 0, 1, 1, 1);
    check("jump0.st", 32'(state), 32'd2);
    check("jump0.y", 32'(ypos), 32'd550);
    ymin = 550;
    for (int k = 1; k <= 33; k++) begin
      frame(1, 0, 0, 0, 1, 1);
      if (32'(ypos) < ymin) ymin = 32'(ypos);
      if (k == 1)  check("air1.y", 32'(ypos), 32'd534);
      if (k == 2)  check("air2.y", 32'(ypos), 32'd519);
      if (k == 17) check("air17.y", 32'(ypos), 32'd414);
      if (k == 32) check("air32.y", 32'(ypos), 32'd534);
    end
    check("land.y", 32'(ypos), 32'd550);
    check("land.st", 32'(state), 32'd3);
    check("peak.y", 32'(ymin), 32'd414);
    frame(1, 0, 0, 0, 1, 1);
    check("after_land.st", 32'(state), 32'd0);

    // Jump held: LAND frame ignores it, re-takeoff on the following tick
    repeat (34) frame(1, 0, 0, 1, 1, 1);
    check("held_land.st", 32'(state), 32'd3);
    frame(1, 0, 0, 1, 1, 1);
    check("held_lock.st", 32'(state), 32'd0);
    frame(1, 0, 0, 1, 1, 1);
    check("held_retake.st", 32'(state), 32'd2);

    // Reset during the ascent at ypos 450
    repeat (8) frame(1, 0, 0, 0, 1, 1);
    check("pre_rst.y", 32'(ypos), 32'd450);
    do_reset(1'b0);
    check("mid_rst.y", 32'(ypos), 32'd550);
    check("mid_rst.x", 32'(xpos), 32'd30);
    check("mid_rst.st", 32'(state), 32'd0);

    // Control withdrawn mid-jump: x frozen, trajectory and landing unaffected
    frame(1, 0, 0, 1, 1, 1);
    repeat (3) frame(1, 0, 1, 0, 1, 1);
    xs = 32'(xpos);
    repeat (30) frame(0, 0, 1, 0, 1, 1);
    check("dis.x", 32'(xpos), 32'(xs));
    check("dis_land.st", 32'(state), 32'd3);
    check("dis_land.y", 32'(ypos), 32'd550);

    // Randomized frames against the model
    for (int n = 0; n < 300; n++) begin
      frame(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 7) == 0),
            int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/player_motion_ctl.md
Name: player_motion_ctl

Overview:
- Per-frame motion controller for one player sprite (cat or dog).
- Turns button requests into a sprite top-left position (xpos, ypos), updated once per frame at the rising edge of vertical blanking.
- Drives the position inputs of the sprite draw stage.
- Implements horizontal walking with screen clamping, plus a jump with integer gravity and a one-frame landing lockout.

Parameters:
X_INIT, 30, reset x position (pixels)
Y_GROUND, 550, ground y position; ypos never exceeds it
X_MIN, 0, leftmost allowed xpos
X_MAX, 894, rightmost allowed xpos (1024 - 130 sprite width)
Y_MIN, 0, topmost allowed ypos (ceiling)
SPEED, 4, horizontal pixels per frame
JUMP_V0, 16, initial upward velocity; must be 1..31
GRAVITY, 1, velocity decrement per frame; must be 1..7

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-low reset
vblnk  in  1  vertical blank from the VGA timing chain
enable  in  1  player control enabled (player's turn)
move_left  in  1  walk-left request (level)
move_right  in  1  walk-right request (level)
jump  in  1  jump request (level)
xpos  out  11  sprite top-left x
ypos  out  11  sprite top-left y
facing_left  out  1  1 = last horizontal move was left (sprite mirror)
state  out  2  0 IDLE, 1 WALK, 2 AIR, 3 LAND
airborne  out  1  1 when state == AIR

Behaviour:
- Reset (rst == 0 at posedge clk):
  - xpos = X_INIT, ypos = Y_GROUND, vy = 0, state = IDLE, facing_left = 0, airborne = 0.
  - vblnk_q = 1, so no spurious tick follows reset release.
- Frame tick:
  - tick = vblnk & ~vblnk_q; vblnk_q registers vblnk every cycle.
  - Exactly one tick per rising edge, however long vblnk stays high.
  - All updates happen on the tick clock edge, so new outputs are visible one cycle after vblnk rises. Between ticks all outputs hold.
- Horizontal (on tick, enable = 1):
  - h_req = left when move_left & ~move_right; right when move_right & ~move_left; none otherwise.
  - Left: xpos = (xpos < X_MIN + SPEED) ? X_MIN : xpos - SPEED; facing_left = 1.
  - Right: xpos = (xpos + SPEED > X_MAX) ? X_MAX : xpos + SPEED; facing_left = 0.
  - Use 12-bit intermediates; no wrap-around.
  - Horizontal moves are allowed in every state, including AIR and LAND.
  - enable = 0: no horizontal change and no new jump.
- Vertical FSM:
  - vy is a signed 6-bit register.
  - IDLE/WALK on tick:
    - If enable & jump: state = AIR, vy = JUMP_V0, ypos unchanged.
    - Otherwise: state = WALK if h_req != none, else IDLE.
  - AIR on tick, with ny = ypos - vy as a 12-bit signed value:
    - If ny >= Y_GROUND: ypos = Y_GROUND, vy = 0, state = LAND.
    - Else if ny < Y_MIN: ypos = Y_MIN, vy = 0, stay AIR (ceiling hit).
    - Else: ypos = ny, vy = vy - GRAVITY.
    - Gravity continues even if enable drops mid-jump.
  - LAND on tick:
    - jump is ignored.
    - state = WALK if h_req != none, else IDLE.
    - Enforces a one-frame lockout, so a held jump re-triggers at the earliest on the second tick after landing.
- Defaults: JUMP_V0 = 16, GRAVITY = 1.
  - Peak ypos = 414, reached after 17 AIR ticks.
  - Landing occurs on the 33rd AIR tick (ypos = 534 on the 32nd).
- Reset mid-jump: immediate return to the reset values on the next clock edge.

Test Plan:
- Reset, then vblnk held high 10 cycles with move_right = 1 -> exactly one tick; xpos = 34 one cycle after vblnk rises, ypos = 550, state = WALK.
- Release reset while vblnk = 1 -> no tick until vblnk falls and rises again; xpos stays 30.
- Xpos at 892, move_right for 2 frames -> xpos 894, 894 (clamped). Then move_left from 2 -> 0 (saturated), facing_left = 1.
- move_left & move_right both 1 for 5 frames -> xpos unchanged, state = IDLE.
- jump pulse on one tick from ground -> state = AIR, ypos 550; next ticks 534, 519, …; min 414 after 17 AIR ticks; 33rd AIR tick gives ypos = 550, state = LAND; next tick IDLE.
- jump held continuously -> LAND frame ignores it; re-takeoff on the following tick.
- rst = 0 during AIR at ypos = 450 -> next edge: ypos = 550, xpos = 30, state = IDLE, vy = 0.
- enable = 0 mid-jump with move_right = 1 -> xpos frozen, ypos trajectory unchanged, landing occurs normally.
